// File: rtl/wb_pkg.sv
// Shared Wishbone constants: error data, peripheral tags, timer register map, byte-lane merge helper.
// Pure declarations, no logic; imported by all Wishbone responders.
package wb_pkg;

    localparam logic [31:0] WB_WRONG_DATA = 32'hDEAD_BEAF;

    localparam logic [2:0] TAG_RAM   = 3'd0;
    localparam logic [2:0] TAG_TIMER = 3'd1;
    localparam logic [2:0] TAG_UART  = 3'd2;
    localparam logic [2:0] TAG_SKIP  = 3'd4;

    typedef enum logic [2:0] {
        TMR_MTIME_LO    = 3'd0,
        TMR_MTIME_HI    = 3'd1,
        TMR_MTIMECMP_LO = 3'd2,
        TMR_MTIMECMP_HI = 3'd3,
        TMR_CTRL        = 3'd4,
        TMR_PRESCALER   = 3'd5,
        TMR_STATUS      = 3'd6,
        TMR_UNMAPPED    = 3'd7
    } tmr_reg_e;

    localparam int CTRL_CNT_EN = 0;
    localparam int CTRL_IRQ_EN = 1;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_dat,
                                               input logic [31:0] new_dat,
                                               input logic [31:0] mask);
        return (old_dat & ~mask) | (new_dat & mask);
    endfunction

endpackage

// File: rtl/wb_slave_if.sv
// Generic Wishbone classic responder front end: request-valid, registered ack, byte-lane write mask.
// Latency: ack one cycle after a valid request, held one cycle; a continuous strobe is acked every other cycle.
module wb_slave_if #(
    parameter int DW = 32,
    parameter int SW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          stb,
    input  logic          cyc,
    input  logic [SW-1:0] sel,
    output logic          req,
    output logic          ack,
    output logic [DW-1:0] wmask
);

    assign req = stb & cyc & ~ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ack <= 1'b0;
        else        ack <= req;
    end

    always_comb begin
        wmask = '0;
        for (int i = 0; i < SW; i++) wmask[8*i +: 8] = {8{sel[i]}};
    end

endmodule

// File: rtl/wb_timer_slave.sv
// Machine timer responder: 64-bit prescaled MTIME, MTIMECMP, CTRL/STATUS, level irq when MTIME >= MTIMECMP.
// Latency: registered ack/data one cycle after request; no backpressure, every request is acked.
module wb_timer_slave
    import wb_pkg::*;
#(
    parameter int          WB_DATA_WIDTH   = 32,
    parameter int          WB_ADDR_WIDTH   = 32,
    parameter int          WB_SEL_WIDTH    = 4,
    parameter int unsigned PRESCALER_RESET = 0
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic [WB_ADDR_WIDTH-1:0] wb_addr_i,
    input  logic [WB_DATA_WIDTH-1:0] wb_data_i,
    input  logic                     wb_we_i,
    input  logic [WB_SEL_WIDTH-1:0]  wb_sel_i,
    input  logic                     wb_stb_i,
    input  logic                     wb_cyc_i,
    output logic                     wb_ack_o,
    output logic [WB_DATA_WIDTH-1:0] wb_data_o,
    output logic                     timer_irq_o
);

    logic                     req;
    logic [WB_DATA_WIDTH-1:0] wmask;
    logic                     wr, rd;
    tmr_reg_e                 offs;

    logic [63:0] mtime, mtime_nxt, mtimecmp;
    logic [1:0]  ctrl;
    logic [15:0] prescaler, pscnt, pscnt_nxt;
    logic [31:0] snap;
    logic [31:0] rd_mux, ctrl_wr, pre_wr;
    logic        tick, match;
    logic        unused_bits;

    wb_slave_if #(.DW(WB_DATA_WIDTH), .SW(WB_SEL_WIDTH)) u_if (
        .clk   (clk_i),
        .rst_n (rst_n_i),
        .stb   (wb_stb_i),
        .cyc   (wb_cyc_i),
        .sel   (wb_sel_i),
        .req   (req),
        .ack   (wb_ack_o),
        .wmask (wmask)
    );

    assign wr    = req & wb_we_i;
    assign rd    = req & ~wb_we_i;
    assign offs  = tmr_reg_e'(wb_addr_i[4:2]);
    assign tick  = ctrl[CTRL_CNT_EN] && (pscnt == prescaler);
    assign match = (mtime >= mtimecmp);

    assign ctrl_wr = byte_merge({30'd0, ctrl}, wb_data_i, wmask);
    assign pre_wr  = byte_merge({16'd0, prescaler}, wb_data_i, wmask);

    assign unused_bits = ^{wb_addr_i[WB_ADDR_WIDTH-1:5], wb_addr_i[1:0],
                           ctrl_wr[31:2], pre_wr[31:16]};

    // A bus write to either half wins outright: no increment or carry lands that cycle.
    always_comb begin
        mtime_nxt = tick ? mtime + 64'd1 : mtime;
        if (wr && offs == TMR_MTIME_LO)
            mtime_nxt = {mtime[63:32], byte_merge(mtime[31:0], wb_data_i, wmask)};
        else if (wr && offs == TMR_MTIME_HI)
            mtime_nxt = {byte_merge(mtime[63:32], wb_data_i, wmask), mtime[31:0]};
    end

    always_comb begin
        pscnt_nxt = pscnt;
        if (wr && offs == TMR_PRESCALER) pscnt_nxt = '0;
        else if (ctrl[CTRL_CNT_EN])      pscnt_nxt = tick ? 16'd0 : pscnt + 16'd1;
    end

    always_comb begin
        rd_mux = WB_WRONG_DATA;
        case (offs)
            TMR_MTIME_LO:    rd_mux = mtime[31:0];
            TMR_MTIME_HI:    rd_mux = snap;
            TMR_MTIMECMP_LO: rd_mux = mtimecmp[31:0];
            TMR_MTIMECMP_HI: rd_mux = mtimecmp[63:32];
            TMR_CTRL:        rd_mux = {30'd0, ctrl};
            TMR_PRESCALER:   rd_mux = {16'd0, prescaler};
            TMR_STATUS:      rd_mux = {31'd0, match};
            default:         rd_mux = WB_WRONG_DATA;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mtime       <= '0;
            mtimecmp    <= '1;
            ctrl        <= '0;
            prescaler   <= 16'(PRESCALER_RESET);
            pscnt       <= '0;
            snap        <= '0;
            timer_irq_o <= 1'b0;
            wb_data_o   <= '0;
        end else begin
            mtime       <= mtime_nxt;
            pscnt       <= pscnt_nxt;
            timer_irq_o <= ctrl[CTRL_IRQ_EN] & match;
            wb_data_o   <= rd ? rd_mux : '0;
            // Low-half read freezes the high half so a following HI read is coherent.
            if (rd && offs == TMR_MTIME_LO) snap <= mtime[63:32];
            if (wr) begin
                case (offs)
                    TMR_MTIMECMP_LO: mtimecmp[31:0]  <= byte_merge(mtimecmp[31:0], wb_data_i, wmask);
                    TMR_MTIMECMP_HI: mtimecmp[63:32] <= byte_merge(mtimecmp[63:32], wb_data_i, wmask);
                    TMR_CTRL:        ctrl            <= ctrl_wr[1:0];
                    TMR_PRESCALER:   prescaler       <= pre_wr[15:0];
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_wb_timer_slave.sv
// Self-checking bench for wb_timer_slave: directed scenarios plus randomized register traffic vs a model.
module tb_wb_timer_slave;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic [31:0] wb_addr_i = '0;
    logic [31:0] wb_data_i = '0;
    logic        wb_we_i = 1'b0;
    logic [3:0]  wb_sel_i = '0;
    logic        wb_stb_i = 1'b0;
    logic        wb_cyc_i = 1'b0;
    logic        wb_ack_o;
    logic [31:0] wb_data_o;
    logic        timer_irq_o;

    int total = 0;
    int bad = 0;
    int cyc_cnt = 0;
    logic irq_at_ack;

    wb_timer_slave #(.PRESCALER_RESET(0)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
        .wb_we_i(wb_we_i), .wb_sel_i(wb_sel_i), .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i),
        .wb_ack_o(wb_ack_o), .wb_data_o(wb_data_o), .timer_irq_o(timer_irq_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc_cnt <= cyc_cnt + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One bus transfer; edge_no is the clock edge that raised ack (and applied a write).
    task automatic bus(input logic we, input logic [2:0] off, input logic [31:0] d,
                       input logic [3:0] s, output logic [31:0] rdat,
                       output int edge_no, output int lat);
        @(negedge clk_i);
        wb_addr_i = {27'd0, off, 2'b00};
        wb_data_i = d; wb_we_i = we; wb_sel_i = s;
        wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
        lat = 0; edge_no = -1; rdat = 'x;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk_i); #1;
            if (wb_ack_o) begin
                lat = i; edge_no = cyc_cnt; rdat = wb_data_o; irq_at_ack = timer_irq_o;
                break;
            end
        end
        wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
        if (lat == 0) begin
            total++; bad++;
            $display("FAIL ack_timeout off=%0d: no ack within 8 cycles", off);
        end
        @(posedge clk_i); #1;
    endtask

    task automatic test_reset();
        logic [31:0] exp [8] = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 32'hDEAD_BEAF};
        logic [31:0] r; int e, l;
        rst_n_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        total++;
        if ({wb_ack_o, wb_data_o, timer_irq_o} !== 34'd0) begin
            bad++; $display("FAIL reset_outputs: got ack=%b data=%h irq=%b, want 0/0/0", wb_ack_o, wb_data_o, timer_irq_o);
        end
        @(negedge clk_i); rst_n_i = 1'b1;
        for (int o = 0; o < 8; o++) begin
            bus(1'b0, 3'(o), 32'h0, 4'h0, r, e, l);
            total++;
            if (r !== exp[o]) begin bad++; $display("FAIL reset_read off=%0d: got %h want %h", o, r, exp[o]); end
            total++;
            if (l !== 1) begin bad++; $display("FAIL reset_ack_lat off=%0d: got %0d want 1", o, l); end
        end
    endtask

    task automatic test_count();
        logic [31:0] r; int e, l, ec, er; logic [63:0] v;
        bus(1'b1, 3'd5, 32'd3, 4'hF, r, e, l);
        bus(1'b1, 3'd4, 32'd1, 4'hF, r, ec, l);
        repeat (38) @(posedge clk_i);
        bus(1'b0, 3'd0, 32'h0, 4'h0, r, er, l);
        v = 64'((er - 1 - ec) / 4);
        total++;
        if (r !== v[31:0]) begin bad++; $display("FAIL count_presc3: got %0d want %0d", r, v[31:0]); end
        bus(1'b1, 3'd4, 32'd0, 4'hF, r, e, l);
        bus(1'b1, 3'd5, 32'd0, 4'hF, r, e, l);
        bus(1'b1, 3'd0, 32'd0, 4'hF, r, e, l);
        bus(1'b1, 3'd1, 32'd0, 4'hF, r, e, l);
        bus(1'b1, 3'd4, 32'd1, 4'hF, r, ec, l);
        for (int k = 0; k < 2; k++) begin
            bus(1'b0, 3'd0, 32'h0, 4'h0, r, er, l);
            total++;
            if (r !== 32'(er - 1 - ec)) begin bad++; $display("FAIL count_presc0_%0d: got %0d want %0d", k, r, er - 1 - ec); end
        end
        bus(1'b0, 3'd1, 32'h0, 4'h0, r, er, l);
        total++;
        if (r !== 32'h0) begin bad++; $display("FAIL count_hi_snap: got %h want 0", r); end
    endtask

    task automatic test_wrap();
        logic [31:0] r; int e, l, ec, er; logic [63:0] v;
        bus(1'b1, 3'd4, 32'd0, 4'hF, r, e, l);
        bus(1'b1, 3'd0, 32'hFFFF_FFFE, 4'hF, r, e, l);
        bus(1'b1, 3'd1, 32'd5, 4'hF, r, e, l);
        bus(1'b1, 3'd4, 32'd1, 4'hF, r, ec, l);
        for (int k = 0; k < 2; k++) begin
            bus(1'b0, 3'd0, 32'h0, 4'h0, r, er, l);
            v = 64'h5_FFFF_FFFE + 64'(er - 1 - ec);
            total++;
            if (r !== v[31:0]) begin bad++; $display("FAIL wrap_lo_%0d: got %h want %h", k, r, v[31:0]); end
            bus(1'b0, 3'd1, 32'h0, 4'h0, r, e, l);
            total++;
            if (r !== v[63:32]) begin bad++; $display("FAIL wrap_hi_snap_%0d: got %h want %h", k, r, v[63:32]); end
        end
    endtask

    task automatic test_irq();
        logic [31:0] r; int e, l, ec, er, k;
        bus(1'b1, 3'd4, 32'd0, 4'hF, r, e, l);
        bus(1'b1, 3'd0, 32'd0, 4'hF, r, e, l);
        bus(1'b1, 3'd1, 32'd0, 4'hF, r, e, l);
        bus(1'b1, 3'd2, 32'h20, 4'hF, r, e, l);
        bus(1'b1, 3'd3, 32'h0, 4'hF, r, e, l);
        bus(1'b1, 3'd4, 32'd3, 4'hF, r, ec, l);
        bus(1'b0, 3'd6, 32'h0, 4'h0, r, er, l);
        total++;
        if (r !== {31'd0, (er - 1 - ec) >= 32'h20}) begin bad++; $display("FAIL status_before: got %h", r); end
        for (int i = 0; i < 80; i++) begin
            @(posedge clk_i); #1;
            k = cyc_cnt - ec;
            if (k == 32'h20) begin
                total++;
                if (timer_irq_o !== 1'b0) begin bad++; $display("FAIL irq_early: got %b want 0", timer_irq_o); end
            end
            if (k == 32'h21) begin
                total++;
                if (timer_irq_o !== 1'b1) begin bad++; $display("FAIL irq_rise: got %b want 1", timer_irq_o); end
                break;
            end
        end
        bus(1'b0, 3'd6, 32'h0, 4'h0, r, er, l);
        total++;
        if (r !== {31'd0, (er - 1 - ec) >= 32'h20}) begin bad++; $display("FAIL status_after: got %h", r); end
        bus(1'b1, 3'd2, 32'h100, 4'hF, r, e, l);
        total++;
        if (irq_at_ack !== 1'b1 || timer_irq_o !== 1'b0) begin
            bad++; $display("FAIL irq_clear: at_ack=%b after=%b want 1/0", irq_at_ack, timer_irq_o);
        end
        bus(1'b0, 3'd6, 32'h0, 4'h0, r, er, l);
        total++;
        if (r !== {31'd0, (er - 1 - ec) >= 32'h100}) begin bad++; $display("FAIL status_cleared: got %h", r); end
        bus(1'b1, 3'd4, 32'd0, 4'hF, r, e, l);
    endtask

    task automatic test_sel();
        logic [31:0] r; int e, l;
        bus(1'b1, 3'd2, 32'hFFFF_FFFF, 4'hF, r, e, l);
        bus(1'b1, 3'd2, 32'hAABB_CCDD, 4'b0101, r, e, l);
        bus(1'b0, 3'd2, 32'h0, 4'h0, r, e, l);
        total++;
        if (r !== 32'hFFBB_FFDD) begin bad++; $display("FAIL sel_0101: got %h want FFBBFFDD", r); end
        bus(1'b1, 3'd2, 32'h1234_5678, 4'b0000, r, e, l);
        total++;
        if (l !== 1) begin bad++; $display("FAIL sel0_ack: got lat %0d want 1", l); end
        bus(1'b0, 3'd2, 32'h0, 4'h0, r, e, l);
        total++;
        if (r !== 32'hFFBB_FFDD) begin bad++; $display("FAIL sel0_unchanged: got %h want FFBBFFDD", r); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r; int e, l;
        bus(1'b1, 3'd3, 32'h1357_2468, 4'hF, r, e, l);
        @(negedge clk_i);
        wb_addr_i = {27'd0, 3'd3, 2'b00}; wb_we_i = 1'b0; wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) begin @(posedge clk_i); #1; end
            total++;
            if (wb_ack_o !== 1'(i % 2) || wb_data_o !== ((i % 2) ? 32'h1357_2468 : 32'h0)) begin
                bad++; $display("FAIL b2b_cycle%0d: got ack=%b data=%h want ack=%0d", i, wb_ack_o, wb_data_o, i % 2);
            end
        end
        wb_stb_i = 1'b0; wb_cyc_i = 1'b0;
        @(posedge clk_i); #1;
    endtask

    task automatic test_reset_mid();
        logic [31:0] r; int e, l;
        bus(1'b1, 3'd2, 32'h0, 4'hF, r, e, l);
        bus(1'b1, 3'd3, 32'h0, 4'hF, r, e, l);
        bus(1'b1, 3'd5, 32'd7, 4'hF, r, e, l);
        bus(1'b1, 3'd4, 32'd3, 4'hF, r, e, l);
        @(negedge clk_i);
        wb_addr_i = {27'd0, 3'd2, 2'b00}; wb_we_i = 1'b0; wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
        @(posedge clk_i); #1;
        total++;
        if (wb_ack_o !== 1'b1) begin bad++; $display("FAIL rstmid_ack_pre: got %b want 1", wb_ack_o); end
        #1 rst_n_i = 1'b0;
        #1;
        total++;
        if ({wb_ack_o, wb_data_o, timer_irq_o} !== 34'd0) begin
            bad++; $display("FAIL rstmid_async: got ack=%b data=%h irq=%b want 0", wb_ack_o, wb_data_o, timer_irq_o);
        end
        wb_stb_i = 1'b0; wb_cyc_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_n_i = 1'b1;
        bus(1'b0, 3'd2, 32'h0, 4'h0, r, e, l);
        total++;
        if (r !== 32'hFFFF_FFFF) begin bad++; $display("FAIL rstmid_cmp: got %h want FFFFFFFF", r); end
        bus(1'b0, 3'd4, 32'h0, 4'h0, r, e, l);
        total++;
        if (r !== 32'h0) begin bad++; $display("FAIL rstmid_ctrl: got %h want 0", r); end
        bus(1'b0, 3'd5, 32'h0, 4'h0, r, e, l);
        total++;
        if (r !== 32'h0) begin bad++; $display("FAIL rstmid_presc: got %h want 0", r); end
        bus(1'b0, 3'd0, 32'h0, 4'h0, r, e, l);
        total++;
        if (r !== 32'h0) begin bad++; $display("FAIL rstmid_mtime: got %h want 0", r); end
    endtask

    // Counting stays disabled here, so the model is a plain register file with byte enables.
    task automatic test_random();
        logic [63:0] mt = '0, cmp = '1;
        logic [31:0] snap = '0, ctrl = '0, pre = '0, cur, exp, r, d;
        logic [3:0]  s;
        logic        we;
        int          off, e, l;
        for (int n = 0; n < 40; n++) begin
            off = $urandom_range(0, 7);
            we  = 1'($urandom_range(0, 1));
            s   = 4'($urandom);
            d   = $urandom;
            if (off == 4) d[0] = 1'b0;
            if (we) begin
                case (off)
                    0: cur = mt[31:0];
                    1: cur = mt[63:32];
                    2: cur = cmp[31:0];
                    3: cur = cmp[63:32];
                    4: cur = ctrl;
                    5: cur = pre;
                    default: cur = '0;
                endcase
                for (int b = 0; b < 4; b++) if (s[b]) cur[8*b +: 8] = d[8*b +: 8];
                case (off)
                    0: mt[31:0]   = cur;
                    1: mt[63:32]  = cur;
                    2: cmp[31:0]  = cur;
                    3: cmp[63:32] = cur;
                    4: ctrl = cur & 32'h3;
                    5: pre  = cur & 32'hFFFF;
                    default: ;
                endcase
                bus(1'b1, 3'(off), d, s, r, e, l);
                total++;
                if (l !== 1) begin bad++; $display("FAIL rnd%0d_wr_lat off=%0d: got %0d want 1", n, off, l); end
            end else begin
                case (off)
                    0: begin exp = mt[31:0]; snap = mt[63:32]; end
                    1: exp = snap;
                    2: exp = cmp[31:0];
                    3: exp = cmp[63:32];
                    4: exp = ctrl;
                    5: exp = pre;
                    6: exp = (mt >= cmp) ? 32'd1 : 32'd0;
                    default: exp = 32'hDEAD_BEAF;
                endcase
                bus(1'b0, 3'(off), 32'h0, 4'h0, r, e, l);
                total++;
                if (r !== exp) begin bad++; $display("FAIL rnd%0d_rd off=%0d: got %h want %h", n, off, r, exp); end
            end
            total++;
            if (timer_irq_o !== (ctrl[1] && (mt >= cmp))) begin
                bad++; $display("FAIL rnd%0d_irq: got %b want %b", n, timer_irq_o, ctrl[1] && (mt >= cmp));
            end
        end
    endtask

    initial begin
        test_reset();
        test_count();
        test_wrap();
        test_irq();
        test_sel();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
